countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Minutes/seconds countdown timer with load, start, pause and expiry.
// The count only moves on a tick while running and saturates at 00:00.
module countdown_timer #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       borrow,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] SEC_MAX = CW'(59);
  localparam logic [CW-1:0] MIN_MAX = CW'(MAX_MIN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] min_q, min_d;
  logic [CW-1:0] sec_q, sec_d;
  logic          borrow_q, borrow_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          done_q, done_d;

  logic [CW-1:0] load_min_clamped;
  logic [CW-1:0] load_sec_clamped;
  logic          count_nz;
  logic          at_one;
  logic          run_tick;

  // Saturate presets and decode count conditions used by both comb blocks.
  always_comb begin
    load_min_clamped = (load_min > MIN_MAX) ? MIN_MAX : load_min;
    load_sec_clamped = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
    count_nz         = (min_q != '0) || (sec_q != '0);
    at_one           = (min_q == '0) && (sec_q == CW'(1));
    // Pause wins over a same-cycle tick; load/start have no effect in RUN.
    run_tick         = tick && !pause;
  end

  // State register plus registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      borrow_q  <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      borrow_q  <= borrow_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  // Next-state selection with load > start > pause > tick priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!load && start && count_nz) state_d = S_RUN;
      end
      S_RUN: begin
        if (pause)                  state_d = S_PAUSED;
        else if (tick && at_one)    state_d = S_EXPIRED;
      end
      S_PAUSED: begin
        if (load)                   state_d = S_IDLE;
        else if (start)             state_d = S_RUN;
      end
      S_EXPIRED: begin
        if (load)                   state_d = S_IDLE;
      end
      default:                      state_d = S_IDLE;
    endcase
  end

  // Next values of the count and the registered flag outputs.
  always_comb begin
    min_d     = min_q;
    sec_d     = sec_q;
    borrow_d  = 1'b0;
    done_d    = 1'b0;
    running_d = (state_d == S_RUN);
    expired_d = (state_d == S_EXPIRED);
    unique case (state_q)
      S_RUN: begin
        if (run_tick) begin
          if (sec_q != '0) begin
            sec_d  = sec_q - CW'(1);
            done_d = at_one;
          end else if (min_q != '0) begin
            sec_d    = SEC_MAX;
            min_d    = min_q - CW'(1);
            borrow_d = 1'b1;
          end
        end
      end
      default: begin
        if (load) begin
          min_d = load_min_clamped;
          sec_d = load_sec_clamped;
        end
      end
    endcase
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign borrow  = borrow_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       borrow;
  logic       running;
  logic       expired;
  logic       done;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.MAX_MIN(59)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .minutes  (minutes),
    .seconds  (seconds),
    .borrow   (borrow),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit later, drop all strobes.
  task automatic step();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int m, input int s,
                           input int b, input int r, input int e, input int d);
    check({tag, ".min"},     32'(minutes), 32'(m));
    check({tag, ".sec"},     32'(seconds), 32'(s));
    check({tag, ".borrow"},  32'(borrow),  32'(b));
    check({tag, ".running"}, 32'(running), 32'(r));
    check({tag, ".expired"}, 32'(expired), 32'(e));
    check({tag, ".done"},    32'(done),    32'(d));
  endtask

  task automatic do_load(input int m, input int s);
    load     = 1'b1;
    load_min = 6'(m);
    load_sec = 6'(s);
    step();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_min = '0; load_sec = '0;
    step();
    check_all("reset", 0, 0, 0, 0, 0, 0);

    // Tick while idle is ignored.
    tick = 1'b1; step();
    check_all("idle_tick", 0, 0, 0, 0, 0, 0);

    // Basic countdown with borrow on minute rollover.
    do_load(1, 2);
    check_all("load_0102", 1, 2, 0, 0, 0, 0);
    start = 1'b1; step();
    check_all("start_0102", 1, 2, 0, 1, 0, 0);
    tick = 1'b1; step();
    check_all("tick1", 1, 1, 0, 1, 0, 0);
    tick = 1'b1; step();
    check_all("tick2", 1, 0, 0, 1, 0, 0);
    tick = 1'b1; step();
    check_all("tick3_borrow", 0, 59, 1, 1, 0, 0);
    step();
    check_all("borrow_drop", 0, 59, 0, 1, 0, 0);

    // Load and start are ignored in RUN.
    load = 1'b1; load_min = 6'd20; load_sec = 6'd20; start = 1'b1; step();
    check_all("run_load_ignored", 0, 59, 0, 1, 0, 0);

    // Pause, reload, run to expiry.
    pause = 1'b1; step();
    check_all("pause", 0, 59, 0, 0, 0, 0);
    do_load(0, 2);
    check_all("load_0002", 0, 2, 0, 0, 0, 0);
    start = 1'b1; step();
    check_all("start_0002", 0, 2, 0, 1, 0, 0);
    tick = 1'b1; step();
    check_all("exp_tick1", 0, 1, 0, 1, 0, 0);
    tick = 1'b1; step();
    check_all("expire", 0, 0, 0, 0, 1, 1);
    step();
    check_all("expire_hold", 0, 0, 0, 0, 1, 0);
    tick = 1'b1; step();
    tick = 1'b1; step();
    check_all("expire_ticks", 0, 0, 0, 0, 1, 0);

    // EXPIRED ignores start and pause; load returns to IDLE.
    start = 1'b1; pause = 1'b1; step();
    check_all("expire_start", 0, 0, 0, 0, 1, 0);
    do_load(0, 3);
    check_all("expire_load", 0, 3, 0, 0, 0, 0);

    // Pause beats a same-cycle tick; ticks ignored while paused.
    do_load(0, 10);
    start = 1'b1; step();
    check_all("run_0010", 0, 10, 0, 1, 0, 0);
    pause = 1'b1; tick = 1'b1; step();
    check_all("pause_tick", 0, 10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; step();
    end
    check_all("paused_ticks", 0, 10, 0, 0, 0, 0);
    start = 1'b1; step();
    check_all("resume", 0, 10, 0, 1, 0, 0);
    tick = 1'b1; step();
    check_all("resume_tick", 0, 9, 0, 1, 0, 0);

    // Reset during RUN discards count; start afterwards is ignored.
    pause = 1'b1; step();
    do_load(12, 34);
    start = 1'b1; step();
    check_all("run_1234", 12, 34, 0, 1, 0, 0);
    reset = 1'b1; tick = 1'b1; start = 1'b1; step();
    check_all("reset_run", 0, 0, 0, 0, 0, 0);
    start = 1'b1; step();
    check_all("start_after_reset", 0, 0, 0, 0, 0, 0);
    load = 1'b1; load_min = 6'd0; load_sec = 6'd5; start = 1'b1; step();
    check_all("load_start_same", 0, 5, 0, 0, 0, 0);

    // Clamping and zero-count start.
    do_load(63, 63);
    check_all("clamp", 59, 59, 0, 0, 0, 0);
    do_load(0, 0);
    check_all("load_zero", 0, 0, 0, 0, 0, 0);
    start = 1'b1; step();
    check_all("start_zero", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
